instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL provide parameter MAX_WORDS, default 256, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'd0, meaning the byte address of program word 0.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 SHALL have port progData  input  32  the program word offered by the host.
REQ-007 SHALL have port progValid  input  1  asserted when progData is valid.
REQ-008 SHALL have port progLast  input  1  marks the final program word; qualified by progValid.
REQ-009 SHALL have port progReady  output  1  loader can accept a word this cycle.
REQ-010 SHALL have port instrAddr  output  32  byte address to instruction memory.
REQ-011 SHALL have port instrIn  output  32  write data to instruction memory.
REQ-012 SHALL have port instrWrite  output  1  instruction-memory write enable.
REQ-013 SHALL have port initializing  output  1  high while the loader owns the instruction-memory address.
REQ-014 SHALL have port pcReset  output  1  holds the program counter in reset.
REQ-015 SHALL have port pcWrite  output  1  enables program-counter update.
REQ-016 SHALL have port wordCount  output  16  number of words written so far.
REQ-017 SHALL have port done  output  1  program loaded and processor released.
REQ-018 SHALL have port overflow  output  1  sticky error: more than MAX_WORDS words offered.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, FLUSH, RUN and ERROR.
REQ-020 SHALL transition IDLE->LOAD on start; in IDLE, progReady=0 and offered words are ignored.
REQ-021 SHALL assert progReady=1 in LOAD only while wordCount<MAX_WORDS; progReady SHALL be 0 in every other state.
REQ-022 SHALL treat a beat as accepted only when progValid&&progReady are high at a rising edge.
REQ-023 SHALL, for a beat accepted at edge N, drive instrIn=progData, instrAddr=BASE_ADDR+4*wordCount(pre-increment) and instrWrite=1 for exactly the cycle after edge N, from registers; wordCount SHALL increment at edge N.
REQ-024 SHALL hold instrWrite=0 in every cycle not following an accepted beat; back-to-back beats SHALL produce back-to-back writes at consecutive addresses.
REQ-025 SHALL transition LOAD->FLUSH on an accepted beat with progLast=1, which is written like any other beat.
REQ-026 SHALL spend exactly one cycle in FLUSH, so that the last write completes, and then enter RUN.
REQ-027 SHALL transition LOAD->ERROR when progValid=1 and wordCount==MAX_WORDS; no write SHALL occur and wordCount SHALL remain MAX_WORDS.
REQ-028 SHALL drive initializing=1 and pcReset=1 in IDLE, LOAD, FLUSH and ERROR; pcWrite=0 in those states.
REQ-029 SHALL drive initializing=0, pcReset=0, pcWrite=1 and done=1 in RUN; RUN and ERROR SHALL be absorbing until reset.
REQ-030 SHALL set overflow=1 in ERROR and hold it until reset; done SHALL be 0 in ERROR.
REQ-031 SHALL ignore start in every state except IDLE.
REQ-032 SHALL compute the address arithmetic modulo 2^32 and keep wordCount from ever exceeding MAX_WORDS.

Reset
REQ-033 SHALL, on a rising edge with reset=1, enter IDLE and set wordCount=0, instrWrite=0, instrIn=0, instrAddr=BASE_ADDR, progReady=0, initializing=1, pcReset=1, pcWrite=0, done=0 and overflow=0.
REQ-034 SHALL let reset override all other inputs, including mid-LOAD; a beat accepted at the reset edge SHALL NOT be written.

Verification
REQ-035 SHALL cover: reset, start, then 2 words 0x00008020 and 0x02108020 (last on 2nd) -> writes at addresses 0 and 4 on consecutive cycles, FLUSH, then pcReset=0, pcWrite=1, done=1, wordCount=2.
REQ-036 SHALL cover: progValid toggling 1/0 during LOAD -> writes occur only after accepted beats, addresses stay contiguous, and no write occurs while progValid=0.
REQ-037 SHALL cover: MAX_WORDS=4 with a 5th word offered -> 4 writes at addresses 0-12, then ERROR with overflow=1, pcReset=1 and no 5th write.
REQ-038 SHALL cover: reset asserted after 3 of 6 accepted words -> next cycle IDLE, wordCount=0, instrWrite=0; a subsequent start reloads from address BASE_ADDR.
REQ-039 SHALL cover: progValid=1 before start, and start pulsed in LOAD/RUN -> no write before start, and no state change from the repeated start.
REQ-040 SHALL cover: BASE_ADDR=32'h400 with a single word carrying last=1 -> one write at 0x400, then RUN with wordCount=1.

Source files
------------

// File: rtl/instr_loader.sv
// Program loader: streams host words into instruction memory while holding the
// processor in reset, then releases the program counter once the last word lands.
module instr_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] progData,
  input  logic        progValid,
  input  logic        progLast,
  output logic        progReady,
  output logic [31:0] instrAddr,
  output logic [31:0] instrIn,
  output logic        instrWrite,
  output logic        initializing,
  output logic        pcReset,
  output logic        pcWrite,
  output logic [15:0] wordCount,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERROR} state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state, stateNext;
  logic [15:0] count_p0;
  logic        vld_p1;
  logic [31:0] data_p1;
  logic [31:0] addr_p1;
  logic        room;
  logic        accept;

  assign room   = (count_p0 < MAX_CNT);
  assign accept = progValid && progReady;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    progReady    = 1'b0;
    initializing = 1'b1;
    pcReset      = 1'b1;
    pcWrite      = 1'b0;
    done         = 1'b0;
    overflow     = 1'b0;
    case (state)
      IDLE: if (start) stateNext = LOAD;
      LOAD: begin
        progReady = room;
        if (accept && progLast)      stateNext = FLUSH;
        else if (progValid && !room) stateNext = ERROR;
      end
      // one spare cycle lets the registered final write reach memory
      FLUSH: stateNext = RUN;
      RUN: begin
        initializing = 1'b0;
        pcReset      = 1'b0;
        pcWrite      = 1'b1;
        done         = 1'b1;
      end
      ERROR:   overflow  = 1'b1;
      default: stateNext = IDLE;
    endcase
  end

  // p0: beat acceptance and word counting
  always_ff @(posedge clk) begin
    if (reset)       count_p0 <= 16'd0;
    else if (accept) count_p0 <= count_p0 + 16'd1;
  end

  // p1: registered memory write, one cycle after the accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= 32'd0;
      addr_p1 <= BASE_ADDR;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= progData;
        addr_p1 <= BASE_ADDR + {14'd0, count_p0, 2'b00};
      end
    end
  end

  assign instrWrite = vld_p1;
  assign instrIn    = data_p1;
  assign instrAddr  = addr_p1;
  assign wordCount  = count_p0;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: DUT 0 (MAX_WORDS=4, base 0) and DUT 1
// (default capacity, base 0x400); expected writes are queued and popped by a monitor.
module tb_instr_loader;

  logic        clk;
  logic        rstS       [2];
  logic        startS     [2];
  logic [31:0] dataS      [2];
  logic        validS     [2];
  logic        lastS      [2];
  logic        readyS     [2];
  logic [31:0] addrS      [2];
  logic [31:0] instrS     [2];
  logic        wrS        [2];
  logic        initS      [2];
  logic        pcRstS     [2];
  logic        pcWrS      [2];
  logic [15:0] cntS       [2];
  logic        doneS      [2];
  logic        ovfS       [2];

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] expAddr[2];
  int          nChecks = 0;
  int          nFail   = 0;

  instr_loader #(.MAX_WORDS(4), .BASE_ADDR(32'd0)) u0 (
    .clk(clk), .reset(rstS[0]), .start(startS[0]), .progData(dataS[0]),
    .progValid(validS[0]), .progLast(lastS[0]), .progReady(readyS[0]),
    .instrAddr(addrS[0]), .instrIn(instrS[0]), .instrWrite(wrS[0]),
    .initializing(initS[0]), .pcReset(pcRstS[0]), .pcWrite(pcWrS[0]),
    .wordCount(cntS[0]), .done(doneS[0]), .overflow(ovfS[0])
  );

  instr_loader #(.BASE_ADDR(32'h400)) u1 (
    .clk(clk), .reset(rstS[1]), .start(startS[1]), .progData(dataS[1]),
    .progValid(validS[1]), .progLast(lastS[1]), .progReady(readyS[1]),
    .instrAddr(addrS[1]), .instrIn(instrS[1]), .instrWrite(wrS[1]),
    .initializing(initS[1]), .pcReset(pcRstS[1]), .pcWrite(pcWrS[1]),
    .wordCount(cntS[1]), .done(doneS[1]), .overflow(ovfS[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wrS[d] === 1'b1) begin
        logic [63:0] e;
        int sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL dut%0d unexpected write: addr %h data %h, expected none", d, addrS[d], instrS[d]);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d write addr", d), addrS[d], e[63:32]);
          chk($sformatf("dut%0d write data", d), instrS[d], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input int d, input logic [31:0] base);
    rstS[d]   = 1'b1;
    startS[d] = 1'b0;
    validS[d] = 1'b0;
    lastS[d]  = 1'b0;
    tick();
    tick();
    rstS[d]    = 1'b0;
    expAddr[d] = base;
  endtask

  task automatic pulseStart(input int d);
    startS[d] = 1'b1;
    tick();
    startS[d] = 1'b0;
  endtask

  task automatic sendWord(input int d, input logic [31:0] w, input logic last);
    if (d == 0) q0.push_back({expAddr[d], w});
    else        q1.push_back({expAddr[d], w});
    expAddr[d] = expAddr[d] + 32'd4;
    dataS[d]   = w;
    lastS[d]   = last;
    validS[d]  = 1'b1;
    tick();
    validS[d]  = 1'b0;
    lastS[d]   = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstS[d] = 1'b1; startS[d] = 1'b0; dataS[d] = 32'd0;
      validS[d] = 1'b0; lastS[d] = 1'b0; expAddr[d] = 32'd0;
    end

    // reset state
    resetDut(1, 32'h400);
    resetDut(0, 32'd0);
    chk("rst instrWrite", wrS[0], 0);
    chk("rst wordCount", cntS[0], 0);
    chk("rst instrAddr", addrS[0], 0);
    chk("rst instrAddr base", addrS[1], 32'h400);
    chk("rst instrIn", instrS[0], 0);
    chk("rst progReady", readyS[0], 0);
    chk("rst initializing", initS[0], 1);
    chk("rst pcReset", pcRstS[0], 1);
    chk("rst pcWrite", pcWrS[0], 0);
    chk("rst done", doneS[0], 0);
    chk("rst overflow", ovfS[0], 0);

    // words offered before start are ignored
    dataS[0] = 32'hBAD0BAD0; validS[0] = 1'b1;
    repeat (3) tick();
    chk("idle progReady", readyS[0], 0);
    chk("idle wordCount", cntS[0], 0);
    validS[0] = 1'b0;

    // basic two-word load
    pulseStart(0);
    chk("load progReady", readyS[0], 1);
    sendWord(0, 32'h00008020, 1'b0);
    sendWord(0, 32'h02108020, 1'b1);
    chk("flush pcReset", pcRstS[0], 1);
    chk("flush done", doneS[0], 0);
    chk("flush progReady", readyS[0], 0);
    tick();
    chk("run done", doneS[0], 1);
    chk("run pcReset", pcRstS[0], 0);
    chk("run pcWrite", pcWrS[0], 1);
    chk("run initializing", initS[0], 0);
    chk("run wordCount", cntS[0], 2);
    pulseStart(0);
    dataS[0] = 32'h11111111; validS[0] = 1'b1;
    tick();
    validS[0] = 1'b0;
    chk("run start ignored done", doneS[0], 1);
    chk("run wordCount hold", cntS[0], 2);

    // progValid toggling; start pulsed mid-load
    resetDut(0, 32'd0);
    pulseStart(0);
    sendWord(0, 32'hA0000001, 1'b0);
    tick();
    sendWord(0, 32'hA0000002, 1'b0);
    pulseStart(0);
    chk("load start ignored ready", readyS[0], 1);
    chk("load start ignored count", cntS[0], 2);
    sendWord(0, 32'hA0000003, 1'b1);
    tick();
    chk("toggle run done", doneS[0], 1);
    chk("toggle wordCount", cntS[0], 3);

    // overflow: capacity 4, fifth word offered
    resetDut(0, 32'd0);
    pulseStart(0);
    sendWord(0, 32'hC0000000, 1'b0);
    sendWord(0, 32'hC0000001, 1'b0);
    sendWord(0, 32'hC0000002, 1'b0);
    sendWord(0, 32'hC0000003, 1'b0);
    chk("full progReady", readyS[0], 0);
    chk("full wordCount", cntS[0], 4);
    dataS[0] = 32'hC0000004; validS[0] = 1'b1;
    tick();
    validS[0] = 1'b0;
    chk("err overflow", ovfS[0], 1);
    chk("err pcReset", pcRstS[0], 1);
    chk("err done", doneS[0], 0);
    chk("err wordCount", cntS[0], 4);
    pulseStart(0);
    tick();
    chk("err sticky overflow", ovfS[0], 1);
    chk("err pcWrite", pcWrS[0], 0);

    // reset mid-load, beat at the reset edge discarded, then reload
    resetDut(0, 32'd0);
    pulseStart(0);
    sendWord(0, 32'hD0000000, 1'b0);
    sendWord(0, 32'hD0000001, 1'b0);
    sendWord(0, 32'hD0000002, 1'b0);
    rstS[0] = 1'b1; dataS[0] = 32'hD0000003; validS[0] = 1'b1;
    tick();
    rstS[0] = 1'b0; validS[0] = 1'b0;
    expAddr[0] = 32'd0;
    chk("midrst wordCount", cntS[0], 0);
    chk("midrst instrWrite", wrS[0], 0);
    chk("midrst progReady", readyS[0], 0);
    pulseStart(0);
    sendWord(0, 32'hE0000000, 1'b1);
    tick();
    chk("reload done", doneS[0], 1);
    chk("reload wordCount", cntS[0], 1);

    // non-zero base address, single last word
    pulseStart(1);
    sendWord(1, 32'hF00DF00D, 1'b1);
    tick();
    chk("base done", doneS[1], 1);
    chk("base wordCount", cntS[1], 1);
    chk("base pcReset", pcRstS[1], 0);

    repeat (3) tick();
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
